// File: rtl/sram_frame_pkg.sv
// Shared types and widths for the SRAM frame-buffer controller and its write FIFO.
package sram_frame_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  // Frame write pointer advance with wrap at the last word of the frame.
  function automatic logic [ADDR_W-1:0] nextWrAddr(input logic [ADDR_W-1:0] cur,
                                                   input logic [ADDR_W-1:0] last);
    return (cur == last) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/sram_wr_fifo.sv
// Small synchronous FIFO holding {address, pixel} write requests for the SRAM controller.
module sram_wr_fifo
  import sram_frame_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        i_push,
  input  fifo_entry_t i_entry,
  input  logic        i_pop,
  output fifo_entry_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_wrIdx;
  logic [PTR_W-1:0] r_rdIdx;
  logic [PTR_W:0]   r_count;
  fifo_entry_t      r_mem [DEPTH];

  logic w_doPush;
  logic w_doPop;

  assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop && !o_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_head   = r_mem[r_rdIdx];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wrIdx <= '0;
      r_rdIdx <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrIdx <= r_wrIdx + 1'b1;
      if (w_doPop)  r_rdIdx <= r_rdIdx + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_doPush) r_mem[r_wrIdx] <= i_entry;
  end

endmodule

// File: rtl/sram_frame_ctrl.sv
// Frame-buffer SRAM arbiter: buffered capture writes vs. display reads, 2-cycle accesses.
// Define SRAM_FRAME_CTRL_DROP_CNT_EN to add the saturating oDROP_CNT dropped-write counter.
module sram_frame_ctrl
  import sram_frame_pkg::*;
#(
  parameter int FRAME_WORDS = 153600,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [DATA_W-1:0] iWR_DATA,
  input  logic              iWR_VALID,
  input  logic              iWR_START,
  input  logic              iRD_REQ,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic              oRD_READY,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oRD_VALID,
  output logic              oFRAME_DONE,
  output logic              oWR_OVERFLOW,
  output logic [DATA_W-1:0] oSRAM_DATA,
  input  logic [DATA_W-1:0] iSRAM_DATA,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_CE_N,
  output logic [1:0]        oSRAM_BE_N
`ifdef SRAM_FRAME_CTRL_DROP_CNT_EN
  ,
  output logic [15:0]       oDROP_CNT
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  state_t            r_state;
  grant_t            r_lastGrant;
  logic [ADDR_W-1:0] r_wrPtr;
  logic              r_frameDone;
  logic              r_overflow;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdValid;
  logic [ADDR_W-1:0] r_sramAddr;
  logic [DATA_W-1:0] r_sramData;
  logic              r_sramWeN;
  logic              r_sramOeN;
  logic              r_sramCeN;
  logic [1:0]        r_sramBeN;

  fifo_entry_t       w_head;
  fifo_entry_t       w_pushEntry;
  logic              w_fifoFull;
  logic              w_fifoEmpty;
  logic              w_rdReady;
  logic              w_grantRead;
  logic              w_grantWrite;
  logic              w_wrAccept;
  logic              w_wrDrop;
  logic [ADDR_W-1:0] w_wrBase;

  // Round-robin: with both sides pending, a read is only offered if the last grant was a write.
  assign w_rdReady    = (r_state == ST_IDLE) && !(!w_fifoEmpty && (r_lastGrant == GRANT_READ));
  assign w_grantRead  = w_rdReady && iRD_REQ;
  assign w_grantWrite = (r_state == ST_IDLE) && !w_fifoEmpty && !w_grantRead;

  assign w_wrBase    = iWR_START ? '0 : r_wrPtr;
  assign w_wrAccept  = iWR_VALID && (!w_fifoFull || w_grantWrite);
  assign w_wrDrop    = iWR_VALID && !w_wrAccept;
  assign w_pushEntry = '{addr: w_wrBase, data: iWR_DATA};

  sram_wr_fifo #(
    .DEPTH (WFIFO_DEPTH)
  ) u_wrFifo (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .i_push  (w_wrAccept),
    .i_entry (w_pushEntry),
    .i_pop   (w_grantWrite),
    .o_head  (w_head),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wrPtr     <= '0;
      r_frameDone <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frameDone <= w_wrAccept && (w_wrBase == LAST_ADDR);
      if (w_wrAccept) begin
        r_wrPtr <= nextWrAddr(w_wrBase, LAST_ADDR);
      end else if (iWR_START) begin
        r_wrPtr <= '0;
      end
      if (w_wrDrop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= ST_IDLE;
      r_lastGrant <= GRANT_WRITE;
      r_rdData    <= '0;
      r_rdValid   <= 1'b0;
      r_sramAddr  <= '0;
      r_sramData  <= '0;
      r_sramWeN   <= 1'b1;
      r_sramOeN   <= 1'b1;
      r_sramCeN   <= 1'b1;
      r_sramBeN   <= 2'b11;
    end else begin
      r_rdValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grantRead) begin
            r_sramAddr  <= iRD_ADDR;
            r_sramCeN   <= 1'b0;
            r_sramOeN   <= 1'b0;
            r_sramWeN   <= 1'b1;
            r_sramBeN   <= 2'b00;
            r_lastGrant <= GRANT_READ;
            r_state     <= ST_READ;
          end else if (w_grantWrite) begin
            r_sramAddr  <= w_head.addr;
            r_sramData  <= w_head.data;
            r_sramCeN   <= 1'b0;
            r_sramWeN   <= 1'b0;
            r_sramOeN   <= 1'b1;
            r_sramBeN   <= 2'b00;
            r_lastGrant <= GRANT_WRITE;
            r_state     <= ST_WRITE;
          end
        end
        ST_READ: begin
          r_rdData  <= iSRAM_DATA;
          r_rdValid <= 1'b1;
          r_sramCeN <= 1'b1;
          r_sramOeN <= 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_WRITE: begin
          r_sramWeN <= 1'b1;
          r_sramCeN <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_sramWeN <= 1'b1;
          r_sramOeN <= 1'b1;
          r_sramCeN <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_FRAME_CTRL_DROP_CNT_EN
  logic [15:0] r_dropCnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_dropCnt <= '0;
    end else if (w_wrDrop && (r_dropCnt != 16'hFFFF)) begin
      r_dropCnt <= r_dropCnt + 1'b1;
    end
  end

  assign oDROP_CNT = r_dropCnt;
`endif

  assign oRD_READY    = w_rdReady;
  assign oRD_DATA     = r_rdData;
  assign oRD_VALID    = r_rdValid;
  assign oFRAME_DONE  = r_frameDone;
  assign oWR_OVERFLOW = r_overflow;
  assign oSRAM_ADDR   = r_sramAddr;
  assign oSRAM_DATA   = r_sramData;
  assign oSRAM_WE_N   = r_sramWeN;
  assign oSRAM_OE_N   = r_sramOeN;
  assign oSRAM_CE_N   = r_sramCeN;
  assign oSRAM_BE_N   = r_sramBeN;

endmodule
